// File: rtl/vec_pkg.sv
// vec_pkg: float format constants, matvec FSM states and lane-slice helpers
package vec_pkg;
    localparam int FP_W = 27;
    localparam int MAX_DIM = 4;
    localparam logic [FP_W-1:0] FP_ONE = 27'h1FC0000;
    localparam logic [FP_W-1:0] FP_ZERO = '0;
    typedef enum logic [2:0] {IDLE, MUL, ADD, WB, DONE} state_t;
    function automatic logic [FP_W-1:0] lane(input logic [MAX_DIM*FP_W-1:0] v, input int i);
        return v[i*FP_W +: FP_W];
    endfunction
    function automatic logic [FP_W-1:0] elem(input logic [MAX_DIM*MAX_DIM*FP_W-1:0] m, input int r, input int c, input int dim);
        return m[(r*dim+c)*FP_W +: FP_W];
    endfunction
endpackage

// File: rtl/vec_fp.sv
// vec_fp: FpMul (combinational) and FpAdd (ADD_LAT-stage pipeline) for the 1/8/18 float.
// Truncating arithmetic; an all-zero exponent reads as zero.
module FpMul import vec_pkg::*; (
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    output logic [FP_W-1:0] o_y
);
    logic [37:0] p;
    logic [9:0] e;
    always_comb begin
        p = 38'({1'b1, i_a[17:0]}) * 38'({1'b1, i_b[17:0]});
        e = {2'b0, i_a[25:18]} + {2'b0, i_b[25:18]} - 10'd127 + {9'b0, p[37]};
        o_y = (i_a[25:18] == '0 || i_b[25:18] == '0 || e[9] || e == '0) ? '0
            : {i_a[26] ^ i_b[26], e[7:0], p[37] ? p[36:19] : p[35:18]};
    end
endmodule

module FpAdd import vec_pkg::*; #(
    parameter int ADD_LAT = 2
) (
    input  logic i_clk,
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    output logic [FP_W-1:0] o_y
);
    logic [FP_W-1:0] big, sml, sum;
    logic [18:0] mb, ms, sh;
    logic [19:0] s;
    logic [4:0] lz;
    logic [FP_W-1:0] pipe [ADD_LAT];
    always_comb begin
        big = (i_a[25:0] >= i_b[25:0]) ? i_a : i_b;
        sml = (i_a[25:0] >= i_b[25:0]) ? i_b : i_a;
        mb = {|big[25:18], big[17:0]};
        ms = {|sml[25:18], sml[17:0]} >> (big[25:18] - sml[25:18]);
        s = (big[26] == sml[26]) ? {1'b0, mb} + {1'b0, ms} : {1'b0, mb} - {1'b0, ms};
        lz = '0;
        for (int i = 0; i < 19; i++) if (s[i]) lz = 5'(18 - i);
        sh = s[18:0] << lz;
        sum = s[19] ? {big[26], big[25:18] + 8'd1, s[18:1]}
            : (s == '0 || big[25:18] <= {3'b0, lz}) ? '0
            : {big[26], big[25:18] - {3'b0, lz}, sh[17:0]};
    end
    always_ff @(posedge i_clk) begin
        pipe[0] <= sum;
        for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign o_y = pipe[ADD_LAT-1];
endmodule

// File: rtl/vec_matvec_seq.sv
// vec_matvec_seq: time-multiplexed o_v = M * v on one FpMul and one FpAdd.
// Rows accumulate in column order; every add waits the full FpAdd latency.
module vec_matvec_seq import vec_pkg::*; #(
    parameter int DIM = 4,
    parameter int FP_W = 27,
    parameter int ADD_LAT = 2,
    parameter bit AFFINE = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic [DIM*DIM*FP_W-1:0] i_m,
    input  logic [DIM*FP_W-1:0] i_v,
    output logic [DIM*FP_W-1:0] o_v,
    output logic o_valid,
    output logic o_busy
);
    localparam int MW = MAX_DIM*MAX_DIM*FP_W;
    localparam int VW = MAX_DIM*FP_W;
    localparam int CW = $clog2(ADD_LAT + 1);
    state_t state;
    logic [1:0] r, c;
    logic [CW-1:0] w;
    logic [MW-1:0] m_q;
    logic [VW-1:0] v_q, v_in;
    logic [FP_W-1:0] acc, prod, sum;
    logic [DIM*FP_W-1:0] res;

    assign v_in = (AFFINE && DIM == 4) ? {FP_ONE, i_v[3*FP_W-1:0]} : VW'(i_v);

    FpMul u_mul (.i_a(elem(m_q, r, c, DIM)), .i_b(lane(v_q, c)), .o_y(prod));

    // The adder sees the live product during MUL, so the sum lands on the last ADD cycle
    FpAdd #(.ADD_LAT(ADD_LAT)) u_add (.i_clk(i_clk), .i_a(acc), .i_b(prod), .o_y(sum));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            r <= '0;
            c <= '0;
            w <= '0;
            acc <= '0;
            res <= '0;
            m_q <= '0;
            v_q <= '0;
            o_v <= {DIM{FP_ZERO}};
            o_valid <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                MUL: if (c == '0) begin
                    acc <= prod;
                    c <= 2'd1;
                end else begin
                    w <= '0;
                    state <= ADD;
                end
                ADD: if (w == CW'(ADD_LAT - 1)) begin
                    acc <= sum;
                    c <= c + 2'd1;
                    state <= (c == 2'(DIM - 1)) ? WB : MUL;
                end else begin
                    w <= w + 1'b1;
                end
                WB: begin
                    res[r*FP_W +: FP_W] <= acc;
                    c <= '0;
                    r <= r + 2'd1;
                    if (r == 2'(DIM - 1)) begin
                        o_v <= {acc, res[(DIM-1)*FP_W-1:0]};
                        o_valid <= 1'b1;
                        o_busy <= 1'b0;
                        state <= DONE;
                    end else begin
                        state <= MUL;
                    end
                end
                default: if (i_start) begin
                    m_q <= MW'(i_m);
                    v_q <= v_in;
                    r <= '0;
                    c <= '0;
                    o_busy <= 1'b1;
                    state <= MUL;
                end else begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
